// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, entry width, configuration field layout and reset bit time
// for the UART receive controller.
package uart_pkg;
    localparam int RX_ENTRY_W    = 11;
    localparam int CFG_W         = 22;
    localparam int CFG_K_W       = 19;
    localparam int CFG_K_LSB     = 3;
    localparam int CFG_EIGHT_BIT = 2;
    localparam int CFG_PEN_BIT   = 1;
    localparam int CFG_EVEN_BIT  = 0;
    localparam logic [CFG_K_W-1:0] RX_K_DEFAULT = 19'd10416;
    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_CLEAR, ST_WAIT} rx_state_e;
    function automatic logic [RX_ENTRY_W-1:0] rx_pack(input logic ovf, input logic ferr,
                                                      input logic perr, input logic [7:0] data);
        return {ovf, ferr, perr, data};
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO; pops while empty are ignored, and a push while full
// is accepted only when a pop frees the head slot in the same cycle.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [RX_ENTRY_W-1:0] wr_data,
    output logic [RX_ENTRY_W-1:0] rd_data,
    output logic [6:0]            count,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);
    logic [RX_ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [6:0]            count_q;
    logic [6:0]            count_d;
    logic                  do_push;
    logic                  do_pop;
    assign empty   = count_q == '0;
    assign full    = count_q == 7'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count_d = count_q + 7'(do_push) - 7'(do_pop);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: captures bytes from a UART receive engine into a FIFO, pulses the engine clear,
// holds engine configuration and raises irq. Define UART_RX_TIMEOUT_EN to add the idle timeout.
module uart_rx_ctrl import uart_pkg::*; #(
    parameter int                 DEPTH       = 8,
    parameter logic [CFG_K_W-1:0] K_DEFAULT   = RX_K_DEFAULT,
    parameter int                 TIMEOUT_CYC = 40000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            eng_data,
    input  logic                  eng_rxrdy,
    input  logic                  eng_ferr,
    input  logic                  eng_perr,
    input  logic                  eng_ovf,
    output logic                  eng_clr,
    output logic [CFG_K_W-1:0]    cfg_k,
    output logic                  cfg_eight,
    output logic                  cfg_pen,
    output logic                  cfg_even,
    input  logic                  cfg_we,
    input  logic [CFG_W-1:0]      cfg_wdata,
    input  logic                  rd_en,
    output logic [RX_ENTRY_W-1:0] rd_data,
    output logic                  rd_valid,
    output logic [6:0]            fifo_count,
    output logic                  fifo_ovf,
    input  logic                  ovf_clr,
    output logic                  irq
);
    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_chk
        $error("uart_rx_ctrl: unsupported DEPTH or TIMEOUT_CYC");
    end
    rx_state_e          state_q;
    logic               eng_clr_q;
    logic               fifo_ovf_q;
    logic               irq_q;
    logic [CFG_K_W-1:0] cfg_k_q;
    logic               cfg_eight_q;
    logic               cfg_pen_q;
    logic               cfg_even_q;
    logic               capture;
    logic               push;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;
    logic               timeout_flag;
    assign capture = state_q == ST_CAPTURE;
    assign pop     = rd_en & ~empty;
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;
    assign rd_valid  = ~empty;
    assign eng_clr   = eng_clr_q;
    assign fifo_ovf  = fifo_ovf_q;
    assign irq       = irq_q;
    assign cfg_k     = cfg_k_q;
    assign cfg_eight = cfg_eight_q;
    assign cfg_pen   = cfg_pen_q;
    assign cfg_even  = cfg_even_q;
    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (rx_pack(eng_ovf, eng_ferr, eng_perr, eng_data)),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );
    // eng_clr is registered so it is high exactly for the single CLEAR cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            eng_clr_q <= 1'b0;
        end else begin
            state_q   <= state_q == ST_IDLE    ? (eng_rxrdy ? ST_CAPTURE : ST_IDLE) :
                         state_q == ST_CAPTURE ? ST_CLEAR :
                         state_q == ST_CLEAR   ? ST_WAIT :
                         (eng_rxrdy ? ST_WAIT : ST_IDLE);
            eng_clr_q <= state_q == ST_CAPTURE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_k_q     <= K_DEFAULT;
            cfg_eight_q <= 1'b1;
            cfg_pen_q   <= 1'b0;
            cfg_even_q  <= 1'b0;
        end else if (cfg_we) begin
            cfg_k_q     <= cfg_wdata[CFG_K_LSB +: CFG_K_W];
            cfg_eight_q <= cfg_wdata[CFG_EIGHT_BIT];
            cfg_pen_q   <= cfg_wdata[CFG_PEN_BIT];
            cfg_even_q  <= cfg_wdata[CFG_EVEN_BIT];
        end
    end
    // A dropped byte wins over a same-cycle clear so no overflow is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_ovf_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            fifo_ovf_q <= drop ? 1'b1 : ovf_clr ? 1'b0 : fifo_ovf_q;
            irq_q      <= (rd_valid & timeout_flag) | fifo_ovf_q | full;
        end
    end
`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] to_cnt_q;
    logic          to_flag_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else if (push || pop || empty) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            to_flag_q <= 1'b1;
        end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end
    assign timeout_flag = to_flag_q;
`else
    assign timeout_flag = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scoreboard bench; expected FIFO entries are queued at send time and
// a monitor compares rd_data on every host pop.
module tb_uart_rx_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  eng_data;
    logic        eng_rxrdy, eng_ferr, eng_perr, eng_ovf;
    logic        eng_clr;
    logic [18:0] cfg_k;
    logic        cfg_eight, cfg_pen, cfg_even;
    logic        cfg_we;
    logic [21:0] cfg_wdata;
    logic        rd_en;
    logic [10:0] rd_data;
    logic        rd_valid;
    logic [6:0]  fifo_count;
    logic        fifo_ovf, ovf_clr, irq;
    logic [10:0] exp_q[$];
    int          total = 0;
    int          passed = 0;
    uart_rx_ctrl #(.DEPTH(8), .K_DEFAULT(19'd10416), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .eng_data(eng_data), .eng_rxrdy(eng_rxrdy),
        .eng_ferr(eng_ferr), .eng_perr(eng_perr), .eng_ovf(eng_ovf), .eng_clr(eng_clr),
        .cfg_k(cfg_k), .cfg_eight(cfg_eight), .cfg_pen(cfg_pen), .cfg_even(cfg_even),
        .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .fifo_count(fifo_count), .fifo_ovf(fifo_ovf),
        .ovf_clr(ovf_clr), .irq(irq)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rd_en && rd_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL rd_data: got 0x%0h, expected no entry", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end
    task automatic send_byte(input logic [7:0] d, input logic fe, input logic pe, input logic ov,
                             input logic accept, input logic pop_cap, input logic chk_lat);
        int   n;
        logic seen;
        @(posedge clk); #1;
        eng_data = d; eng_ferr = fe; eng_perr = pe; eng_ovf = ov; eng_rxrdy = 1'b1;
        if (accept) exp_q.push_back({ov, fe, pe, d});
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(posedge clk); #1;
            n++;
            rd_en = pop_cap && n == 1;
            seen = eng_clr;
        end
        rd_en = 1'b0;
        check("clr_seen", seen, 1);
        if (chk_lat) begin
            check("clr_latency", n, 2);
            check("latency_valid", rd_valid, 1);
        end
        eng_rxrdy = 1'b0;
        @(posedge clk); #1;
        if (chk_lat) check("clr_single_pulse", eng_clr, 0);
        @(posedge clk); #1;
    endtask
    task automatic pop_one();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask
    task automatic reset_checks();
        check("rst_cfg_k", cfg_k, 19'd10416);
        check("rst_cfg_eight", cfg_eight, 1);
        check("rst_cfg_pen", cfg_pen, 0);
        check("rst_cfg_even", cfg_even, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_fifo_ovf", fifo_ovf, 0);
        check("rst_eng_clr", eng_clr, 0);
        check("rst_irq", irq, 0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        rst_n = 1'b0; eng_data = '0; eng_rxrdy = 0; eng_ferr = 0; eng_perr = 0; eng_ovf = 0;
        cfg_we = 0; cfg_wdata = '0; rd_en = 0; ovf_clr = 0;
        repeat (3) @(posedge clk);
        #1 reset_checks();
        rst_n = 1'b1;
        send_byte(8'hA5, 0, 0, 0, 1, 0, 1);
        check("a5_count", fifo_count, 1);
        pop_one();
        check("a5_empty", rd_valid, 0);
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 0, 0, 0, 1, 0, 0);
        check("full_count", fifo_count, 8);
        check("full_no_ovf", fifo_ovf, 0);
        send_byte(8'h99, 0, 0, 0, 0, 0, 0);
        check("drop_count", fifo_count, 8);
        check("drop_ovf", fifo_ovf, 1);
        check("drop_irq", irq, 1);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        check("ovf_cleared", fifo_ovf, 0);
        send_byte(8'h77, 0, 0, 0, 1, 1, 0);
        check("full_pop_count", fifo_count, 8);
        check("full_pop_ovf", fifo_ovf, 0);
        repeat (8) pop_one();
        check("drained_count", fifo_count, 0);
        check("drained_valid", rd_valid, 0);
        check("queue_empty", exp_q.size(), 0);
        pop_one();
        check("empty_pop_count", fifo_count, 0);
        send_byte(8'h3C, 1, 1, 0, 1, 0, 0);
        send_byte(8'h5A, 0, 0, 1, 1, 0, 0);
        check("err_count", fifo_count, 2);
        pop_one();
        pop_one();
        @(posedge clk); #1;
        cfg_wdata = {19'd5208, 1'b0, 1'b1, 1'b1};
        cfg_we = 1'b1;
        @(posedge clk); #1 cfg_we = 1'b0;
        check("cfg_k", cfg_k, 19'd5208);
        check("cfg_eight", cfg_eight, 0);
        check("cfg_pen", cfg_pen, 1);
        check("cfg_even", cfg_even, 1);
        check("cfg_no_fifo", fifo_count, 0);
        send_byte(8'hE1, 0, 0, 0, 1, 0, 0);
        check("pre_rst_valid", rd_valid, 1);
        rst_n = 1'b0;
        #2 reset_checks();
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
`ifdef UART_RX_TIMEOUT_EN
        begin
            int n;
            send_byte(8'h42, 0, 0, 0, 1, 0, 0);
            repeat (10) @(posedge clk);
            #1 check("to_irq_early", irq, 0);
            n = 0;
            while (!irq && n < 12) begin
                @(posedge clk); #1;
                n++;
            end
            check("to_irq_set", irq, 1);
            pop_one();
            repeat (2) @(posedge clk);
            #1 check("to_irq_clear", irq, 0);
        end
`endif
        repeat (2) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The parameters SHALL be:
- DEPTH, 8, FIFO entries, power of two, 2..64.
- K_DEFAULT, 19'd10416, reset bit-time count.
- TIMEOUT_CYC, 40000, idle cycles before timeout.

REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.

REQ-003 The ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- eng_data, in, 8, receive engine byte.
- eng_rxrdy, in, 1, engine byte ready.
- eng_ferr, in, 1, engine framing error.
- eng_perr, in, 1, engine parity error.
- eng_ovf, in, 1, engine overrun.
- eng_clr, out, 1, clear pulse to engine.
- cfg_k, out, 19, engine bit-time count.
- cfg_eight, out, 1, engine 8-bit mode.
- cfg_pen, out, 1, engine parity enable.
- cfg_even, out, 1, engine even parity.
- cfg_we, in, 1, configuration write strobe.
- cfg_wdata, in, 22, {k[18:0], eight, pen, even}.
- rd_en, in, 1, host pop.
- rd_data, out, 11, {ovf, ferr, perr, data[7:0]} at FIFO head.
- rd_valid, out, 1, FIFO not empty.
- fifo_count, out, 7, occupancy.
- fifo_ovf, out, 1, sticky FIFO overflow.
- ovf_clr, in, 1, clears fifo_ovf.
- irq, out, 1, interrupt.

Function
REQ-004 The FSM SHALL have states IDLE, CAPTURE, CLEAR and WAIT.
- IDLE goes to CAPTURE when eng_rxrdy=1.
- CAPTURE goes to CLEAR unconditionally.
- CLEAR goes to WAIT unconditionally.
- WAIT goes to IDLE when eng_rxrdy=0.

REQ-005 In CAPTURE, the block SHALL push {eng_ovf, eng_ferr, eng_perr, eng_data} if the FIFO is not full, or if a pop occurs in the same cycle; otherwise it SHALL drop the byte and set fifo_ovf.

REQ-006 eng_clr SHALL be high for exactly one cycle, while in CLEAR; it SHALL be registered, and it SHALL never be high in any other state.

REQ-007 Latency SHALL be two cycles from eng_rxrdy sampled high in IDLE to the entry being visible on rd_data/rd_valid (when the FIFO was empty).

REQ-008 The FIFO SHALL be show-ahead: rd_data always shows the head entry, and rd_en while empty SHALL be ignored with no pointer or count change.

REQ-009 A simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH; fifo_count SHALL range 0..DEPTH.

REQ-010 fifo_ovf SHALL be sticky: set has priority over ovf_clr in the same cycle.

REQ-011 cfg_we SHALL load cfg_k, cfg_eight, cfg_pen and cfg_even on the next edge, regardless of FSM state; there SHALL be no FIFO side effect.

REQ-012 irq SHALL equal (rd_valid & timeout_flag) | fifo_ovf | (fifo_count==DEPTH), registered.

Reset
REQ-013 On rst_n low, the block SHALL asynchronously force:
- FSM=IDLE, pointers=0, fifo_count=0.
- rd_valid=0, fifo_ovf=0, eng_clr=0, irq=0.
- cfg_k=K_DEFAULT, cfg_eight=1, cfg_pen=0, cfg_even=0.

REQ-014 Reset mid-operation SHALL discard all FIFO contents; rd_data is don't-care while rd_valid=0.

Configuration
REQ-015 With UART_RX_TIMEOUT_EN defined, the timeout counter SHALL behave as follows:
- It increments while rd_valid=1 and no push or pop occurs.
- It resets to 0 on any push or pop, or when empty.
- It sets timeout_flag when the count reaches TIMEOUT_CYC-1.
- timeout_flag clears on the next push or pop.

REQ-016 Without UART_RX_TIMEOUT_EN, no counter SHALL be synthesised and timeout_flag SHALL be constant 0.

Structure
REQ-017 Package uart_pkg SHALL hold:
- the FSM state encoding;
- RX_ENTRY_W=11;
- the cfg field widths/offsets;
- the K_DEFAULT value.

REQ-018 Storage and pointers SHALL live in the sub-module uart_rx_fifo; the FSM, configuration registers, timeout and irq SHALL reside in uart_rx_ctrl.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- eng_rxrdy=1 with eng_data=8'hA5 and no errors -> eng_clr single pulse 2 cycles later; rd_data=11'h0A5; rd_valid=1.
- 9 bytes with no pops (DEPTH=8) -> fifo_count=8; 9th byte dropped; fifo_ovf=1; irq=1; ovf_clr -> fifo_ovf=0.
- Full FIFO with rd_en coincident with CAPTURE -> byte accepted; fifo_count stays 8; fifo_ovf=0.
- eng_ferr=1 and eng_perr=1 with data 8'h3C -> rd_data=11'h33C.
- cfg_we with k=19'd5208, eight=0, pen=1, even=1 -> cfg outputs updated next cycle; rst_n low -> defaults restored and rd_valid=0.
- UART_RX_TIMEOUT_EN with TIMEOUT_CYC=16: one entry and no activity -> irq=1 after 16 cycles; pop -> irq=0.
